// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with valid/ready handshaking,
// flush, NOP-forced bubble control and a saturating backpressure counter.
module pipe_stage_reg #(
    parameter int DATA_W = 132,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic accept;
    logic pop;

    // Handshake outputs come from registered state only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign stall_cnt = stall_cnt_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        stall_cnt_d = stall_cnt_q;

        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (accept) begin
                        state_d     = TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // NOTE: payload registers are deliberately left without reset; validity is
    // carried by the state, and out_ctrl is gated so stale contents never leak.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        main_ctrl_q <= main_ctrl_d;
        skid_data_q <= skid_data_d;
        skid_ctrl_q <= skid_ctrl_d;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded random bench for pipe_stage_reg, instantiated with a
// 3-bit stall counter so saturation is reachable in a few cycles.
module tb_pipe_stage_reg;

    localparam int DATA_W = 132;
    localparam int CTRL_W = 10;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 132'hDEAD, 10'h3FF);
        step();
        rst = 1'b0;
        drive(1'b0, '0, '0);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_ctrl !== '0) $display("FAIL reset_out_ctrl got %h exp 0", out_ctrl);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 3'd0) $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, DATA_W'(i), CTRL_W'(i + 8));
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL stream_in_ready_%0d got %b exp 1", i, in_ready);
            else pass_cnt++;
            step();
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || out_ctrl !== CTRL_W'(i + 8))
                $display("FAIL stream_out_%0d got v=%b d=%h c=%h exp v=1 d=%h c=%h",
                         i, out_valid, out_data, out_ctrl, i, i + 8);
            else pass_cnt++;
        end
        drive(1'b0, 132'hBAD, 10'h155);
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || out_ctrl !== '0)
            $display("FAIL stream_drain got v=%b c=%h exp v=0 c=0", out_valid, out_ctrl);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 3'd0) $display("FAIL stream_stall_cnt got %0d exp 0", stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 132'hA, 10'h0A);
        step();
        total_cnt++;
        if (out_data !== 132'hA || in_ready !== 1'b1)
            $display("FAIL bp_one got d=%h rdy=%b exp d=a rdy=1", out_data, in_ready);
        else pass_cnt++;
        drive(1'b1, 132'hB, 10'h0B);
        step();
        drive(1'b1, 132'hC, 10'h0C);
        total_cnt++;
        if (in_ready !== 1'b0 || out_data !== 132'hA || stall_cnt !== 3'd1)
            $display("FAIL bp_two got rdy=%b d=%h cnt=%0d exp rdy=0 d=a cnt=1", in_ready, out_data, stall_cnt);
        else pass_cnt++;
        step();
        total_cnt++;
        if (in_ready !== 1'b0 || out_data !== 132'hA || stall_cnt !== 3'd2)
            $display("FAIL bp_hold got rdy=%b d=%h cnt=%0d exp rdy=0 d=a cnt=2", in_ready, out_data, stall_cnt);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        total_cnt++;
        if (out_data !== 132'hB || out_ctrl !== 10'h0B || in_ready !== 1'b1 || stall_cnt !== 3'd2)
            $display("FAIL bp_release_b got d=%h c=%h rdy=%b cnt=%0d exp d=b c=b rdy=1 cnt=2",
                     out_data, out_ctrl, in_ready, stall_cnt);
        else pass_cnt++;
        step();
        drive(1'b0, '0, '0);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 132'hC || out_ctrl !== 10'h0C)
            $display("FAIL bp_release_c got v=%b d=%h c=%h exp v=1 d=c c=c", out_valid, out_data, out_ctrl);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_empty got v=%b exp 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 132'h11, 10'h011);
        step();
        drive(1'b1, 132'h22, 10'h022);
        step();
        flush = 1'b1;
        drive(1'b1, 132'h33, 10'h033);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        total_cnt++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1)
            $display("FAIL flush_two got v=%b c=%h rdy=%b exp v=0 c=0 rdy=1", out_valid, out_ctrl, in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL flush_stale_%0d got v=%b d=%h exp v=0", i, out_valid, out_data);
            else pass_cnt++;
        end
        // Flush together with a pop and a new input from state ONE.
        drive(1'b1, 132'h44, 10'h044);
        step();
        flush = 1'b1;
        drive(1'b1, 132'h55, 10'h055);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        total_cnt++;
        if (out_valid !== 1'b0 || out_ctrl !== '0)
            $display("FAIL flush_one_pop got v=%b c=%h exp v=0 c=0", out_valid, out_ctrl);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 132'h77, 10'h077);
        step();
        drive(1'b0, 132'hFFFF, 10'h3FF);
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_cnt = (i > 7) ? 7 : i;
            total_cnt++;
            if (stall_cnt !== CNT_W'(exp_cnt))
                $display("FAIL sat_cnt_%0d got %0d exp %0d", i, stall_cnt, exp_cnt);
            else pass_cnt++;
        end
        total_cnt++;
        if (out_data !== 132'h77 || out_ctrl !== 10'h077)
            $display("FAIL sat_hold got d=%h c=%h exp d=77 c=77", out_data, out_ctrl);
        else pass_cnt++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        total_cnt++;
        if (stall_cnt !== 3'd7 || out_valid !== 1'b0)
            $display("FAIL sat_after_flush got cnt=%0d v=%b exp cnt=7 v=0", stall_cnt, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 132'h91, 10'h091);
        step();
        drive(1'b1, 132'h92, 10'h092);
        step();
        step();
        rst = 1'b1; flush = 1'b1;
        drive(1'b1, 132'h93, 10'h093);
        step();
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, '0, '0);
        total_cnt++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || stall_cnt !== 3'd0 || in_ready !== 1'b1)
            $display("FAIL reset_mid got v=%b c=%h cnt=%0d rdy=%b exp v=0 c=0 cnt=0 rdy=1",
                     out_valid, out_ctrl, stall_cnt, in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_mid_stay got v=%b exp 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        logic exp_pop, exp_acc;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            total_cnt++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2))
                $display("FAIL rnd_hs_%0d got v=%b rdy=%b exp v=%b rdy=%b",
                         cyc, out_valid, in_ready, q.size() > 0, q.size() < 2);
            else pass_cnt++;
            total_cnt++;
            if (q.size() > 0) begin
                if (out_data !== q[0].d || out_ctrl !== q[0].c)
                    $display("FAIL rnd_head_%0d got d=%h c=%h exp d=%h c=%h",
                             cyc, out_data, out_ctrl, q[0].d, q[0].c);
                else pass_cnt++;
            end else begin
                if (out_ctrl !== '0) $display("FAIL rnd_bubble_%0d got c=%h exp 0", cyc, out_ctrl);
                else pass_cnt++;
            end
            e.d = {4'($urandom_range(15, 0)), $urandom(), $urandom(), $urandom(), $urandom()};
            e.c = CTRL_W'($urandom()) | CTRL_W'(1);
            drive($urandom_range(0, 3) != 0, e.d, e.c);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            exp_pop = (q.size() > 0) && out_ready;
            exp_acc = in_valid && (q.size() < 2);
            step();
            if (flush) begin
                q.delete();
            end else begin
                if (exp_pop) void'(q.pop_front());
                if (exp_acc) q.push_back(e);
            end
        end
        flush = 1'b0;
        drive(1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
